// File: rtl/mac_window_pkg.sv
// Shared types and helpers for the a*b+c sliding-window stream unit.
package mac_window_pkg;

  // Result width-reduction policy.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Number of consecutive samples that make up one window.
  localparam int WIN = 3;

  // Width that holds a*b+c for DW-bit unsigned operands without loss.
  function automatic int full_width(input int dw);
    return (2 * dw) + 1;
  endfunction

endpackage

// File: rtl/mac_sat_stage.sv
// Combinational a*b+c with width reduction to OW bits, overflow detection
// and WRAP/SAT selection.
module mac_sat_stage
  import mac_window_pkg::*;
#(
  parameter int    DW   = 32,
  parameter int    OW   = 32,
  parameter mode_e MODE = MODE_WRAP
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic [OW-1:0] result,
  output logic          ovf
);

  localparam int FW = full_width(DW);

  logic [FW-1:0] full_s;
  logic          ovf_s;

  // Full-precision multiply-add; FW bits can never overflow.
  always_comb begin
    full_s = FW'(a) * FW'(b) + FW'(c);
  end

  // Overflow means any bit above the kept OW bits is set.
  generate
    if (OW < FW) begin : g_narrow
      assign ovf_s = |full_s[FW-1:OW];
    end else begin : g_full
      assign ovf_s = 1'b0;
    end
  endgenerate

  // Select wrapped or saturated result.
  always_comb begin
    ovf = ovf_s;
    if ((MODE == MODE_SAT) && ovf_s) begin
      result = {OW{1'b1}};
    end else begin
      result = full_s[OW-1:0];
    end
  end

endmodule

// File: rtl/mac_window_pipe.sv
// Sliding 3-sample window over a valid-qualified stream; each completed window
// yields a*b+c (oldest*middle+newest) after a LAT-cycle output pipeline.
module mac_window_pipe
  import mac_window_pkg::*;
#(
  parameter int DW   = 32,
  parameter int OW   = 32,
  parameter int MODE = 0,
  parameter int LAT  = 1
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          validi,
  input  logic [DW-1:0] data_in,
  input  logic          clr,
  output logic          valido,
  output logic [OW-1:0] data_out,
  output logic          ovf
);

  localparam mode_e      MODE_SEL = (MODE == 1) ? MODE_SAT : MODE_WRAP;
  localparam logic [1:0] CNT_FULL = 2'(WIN - 1);

  logic [1:0]    cnt_r;
  logic [DW-1:0] h1_r;
  logic [DW-1:0] h2_r;
  logic          fire_s;
  logic [OW-1:0] res_s;
  logic          res_ovf_s;

  logic          vld_r [LAT];
  logic [OW-1:0] dat_r [LAT];
  logic          ovf_r [LAT];

  // A window completes when a third consecutive valid sample arrives without clr.
  always_comb begin
    fire_s = 1'b0;
    if (validi && !clr && (cnt_r == CNT_FULL)) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
  end

  mac_sat_stage #(
    .DW   (DW),
    .OW   (OW),
    .MODE (MODE_SEL)
  ) u_sat (
    .a      (h2_r),
    .b      (h1_r),
    .c      (data_in),
    .result (res_s),
    .ovf    (res_ovf_s)
  );

  // Run counter and sample history; clr discards the window, a gap restarts the run.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_r <= 2'd0;
      h1_r  <= {DW{1'b0}};
      h2_r  <= {DW{1'b0}};
    end else if (clr) begin
      cnt_r <= 2'd0;
      h1_r  <= {DW{1'b0}};
      h2_r  <= {DW{1'b0}};
    end else if (validi) begin
      if (cnt_r != CNT_FULL) begin
        cnt_r <= cnt_r + 2'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      h2_r <= h1_r;
      h1_r <= data_in;
    end else begin
      cnt_r <= 2'd0;
    end
  end

  // Output pipeline: valid shifts every cycle, data moves only behind a valid
  // stage so the last stage keeps its last result while idle.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < LAT; i++) begin
        vld_r[i] <= 1'b0;
        dat_r[i] <= {OW{1'b0}};
        ovf_r[i] <= 1'b0;
      end
    end else begin
      vld_r[0] <= fire_s;
      ovf_r[0] <= fire_s & res_ovf_s;
      if (fire_s) begin
        dat_r[0] <= res_s;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        ovf_r[i] <= vld_r[i-1] & ovf_r[i-1];
        if (vld_r[i-1]) begin
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  assign valido   = vld_r[LAT-1];
  assign data_out = dat_r[LAT-1];
  assign ovf      = ovf_r[LAT-1];

endmodule
